// File: rtl/riscv_bus_pkg.sv
// Shared constants and types for the load/store bus demultiplexer: address map,
// FSM state encoding and the latched request record.
package riscv_bus_pkg;

    localparam int unsigned NUM_SLAVES = 5;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned CNT_W      = 8;

    // Packed arrays: element [i] is slave i.
    localparam logic [NUM_SLAVES-1:0][31:0] REGION_BASE = {
        32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [NUM_SLAVES-1:0][31:0] REGION_MASK = {
        32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000
    };

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: maps a byte address onto a slave index using the
// package region table. The lowest matching index wins.
module bus_addr_decode
    import riscv_bus_pkg::*;
(
    input  logic [31:0]      addr_i,
    output logic             hit_o,
    output logic [SEL_W-1:0] sel_o
);

    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        // Walk from the top so a lower index overrides any higher match.
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((addr_i & REGION_MASK[i]) == REGION_BASE[i]) begin
                hit_o = 1'b1;
                sel_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_demux5.sv
// Single-master to five-slave bus demultiplexer with one outstanding transaction,
// error responses for unmapped addresses and slave timeouts.
module bus_demux5
    import riscv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_req_valid,
    output logic                     m_req_ready,
    input  logic [31:0]              m_req_addr,
    input  logic                     m_req_we,
    input  logic [31:0]              m_req_wdata,
    input  logic [3:0]               m_req_be,
    output logic                     m_rsp_valid,
    input  logic                     m_rsp_ready,
    output logic [31:0]              m_rsp_rdata,
    output logic                     m_rsp_err,
    output logic [NUM_SLAVES-1:0]    s_req_valid,
    input  logic [NUM_SLAVES-1:0]    s_req_ready,
    output logic [31:0]              s_req_addr,
    output logic                     s_req_we,
    output logic [31:0]              s_req_wdata,
    output logic [3:0]               s_req_be,
    input  logic [NUM_SLAVES-1:0]    s_rsp_valid,
    input  logic [NUM_SLAVES*32-1:0] s_rsp_rdata,
    output logic [SEL_W-1:0]         sel
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    bus_req_t         req_q, req_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             dec_hit;
    logic [SEL_W-1:0] dec_sel;
    logic             sel_ready;
    logic             sel_rsp_valid;
    logic [31:0]      sel_rsp_rdata;

    bus_addr_decode u_decode (
        .addr_i (m_req_addr),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel)
    );

    // Pick out the owning slave's handshake and data lanes.
    always_comb begin
        sel_ready     = 1'b0;
        sel_rsp_valid = 1'b0;
        sel_rsp_rdata = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready     = s_req_ready[i];
                sel_rsp_valid = s_rsp_valid[i];
                sel_rsp_rdata = s_rsp_rdata[i*32 +: 32];
            end
        end
    end

    assign cnt_inc = (cnt_q < TIMEOUT_CNT) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (m_req_valid) begin
                    req_d.addr  = m_req_addr;
                    req_d.we    = m_req_we;
                    req_d.wdata = m_req_wdata;
                    req_d.be    = m_req_be;
                    sel_d       = dec_sel;
                    cnt_d       = '0;
                    rdata_d     = '0;
                    err_d       = ~dec_hit;
                    state_d     = dec_hit ? StIssue : StResp;
                end
            end
            StIssue: begin
                cnt_d = cnt_inc;
                if (sel_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                // A response arriving on the timeout cycle still counts as success.
                if (sel_rsp_valid) begin
                    rdata_d = sel_rsp_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (m_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign m_req_ready = (state_q == StIdle);
    assign m_rsp_valid = (state_q == StResp);
    assign m_rsp_rdata = rdata_q;
    assign m_rsp_err   = err_q;
    assign s_req_valid = (state_q == StIssue) ? (NUM_SLAVES'(1) << sel_q) : '0;
    assign s_req_addr  = req_q.addr;
    assign s_req_we    = req_q.we;
    assign s_req_wdata = req_q.wdata;
    assign s_req_be    = req_q.be;
    assign sel         = sel_q;

endmodule
